stream_mux_1ofn: RTL and testbench
==================================

// Module: stream_mux_1OfN
// PURPOSE
// - N:1 registered stream multiplexer with valid/ready handshake and packet locking.
// - Generalises the registered 1-of-N select mux:
//   - per-port backpressure;
//   - fixed-select or round-robin arbitration;
//   - grant held for a whole packet (until in_last).
// - Sits between the GACT tile result ports and the shared traceback/host output stream.
// PARAMETERS
// - NUM_PORTS_WIDTH  2   log2 of the input port count; NUM_PORTS = 2**NUM_PORTS_WIDTH.
// - DATA_WIDTH       32  payload width per beat.
// - RR_MODE          1   0: port chosen by select; 1: round-robin among valid ports.
// PORTS
// - clk        in   1                    clock, all logic on posedge.
// - rst        in   1                    synchronous active-high reset.
// - select     in   NUM_PORTS_WIDTH      port to grant when RR_MODE=0; sampled only in IDLE.
// - in_valid   in   NUM_PORTS            per-port beat valid.
// - in_ready   out  NUM_PORTS            per-port beat accepted this cycle (combinational).
// - in_data    in   NUM_PORTS*DATA_WIDTH port i occupies bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
// - in_last    in   NUM_PORTS            per-port end-of-packet flag.
// - out_valid  out  1                    output register holds a beat.
// - out_ready  in   1                    downstream accepts the beat.
// - out_data   out  DATA_WIDTH           registered payload.
// - out_last   out  1                    registered end-of-packet flag.
// - out_port   out  NUM_PORTS_WIDTH      index of the port the beat came from.
// BEHAVIOUR
// Reset
// - out_valid=0, out_data=0, out_last=0, out_port=0; state=IDLE; rr_ptr=NUM_PORTS-1.
// - in_ready=0 during reset.
// Load condition
// - load_ok = !out_valid || out_ready.
// - One beat of output storage gives full throughput of 1 beat/cycle with out_ready high.
// States
// - IDLE: no port locked.
//   - Candidate port, evaluated combinationally:
//     - RR_MODE=0: cand = select, valid only if in_valid[select].
//     - RR_MODE=1: first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
//   - If a candidate exists and load_ok: in_ready[cand]=1 and the beat transfers this cycle.
//   - On that transfer, rr_ptr<=cand.
//   - If in_last=0, go to LOCK with grant<=cand; if in_last=1, stay in IDLE.
// - LOCK: only port grant is eligible.
//   - in_ready[grant] = load_ok; every other in_ready is 0.
//   - A transfer with in_last[grant]=1 returns to IDLE.
//   - select changes and other ports' valids are ignored.
//   - grant deasserting in_valid mid-packet: stay in LOCK and stall; no bubble insertion.
// Transfer
// - Input beat accepted at edge t appears on out_* after edge t (1-cycle latency).
// - out_port = source index.
// - If out_ready=1 and there is no new transfer: out_valid<=0 and out_data holds its value.
// - If out_valid=1 and out_ready=0: out_* hold stable, and in_ready is all 0.
// - At most one in_ready bit is high in any cycle (one-hot or zero).
// Boundary conditions
// - Single-beat packet (in_last on the first beat): no LOCK entry; the next arbitration happens the following cycle.
// - Round-robin wrap: if rr_ptr = NUM_PORTS-1, the search starts at port 0.
// - All ports valid continuously in RR mode: packets are granted 0,1,2,3,0,... with no port starved.
// - rst asserted mid-packet: the packet is abandoned; the output beat is dropped (out_valid=0); state=IDLE.
//   - Upstream is responsible for resending after reset.
// - select out of range cannot occur, because width is exact.
// TESTING
// - T1 reset: hold rst 3 cycles with all in_valid=1.
//   -> in_ready=0, out_valid=0, out_data=0, out_port=0.
// - T2 RR_MODE=0, select=2, port2 sends 3-beat packet A0..A2 (last on A2), out_ready=1.
//   -> out_data A0,A1,A2 on 3 consecutive cycles, one cycle after each input.
//   -> out_port=2; out_last only on A2.
// - T3 RR_MODE=1, all 4 ports send 1-beat packets continuously, out_ready=1.
//   -> out_port sequence 0,1,2,3,0,1 with no idle cycle.
// - T4 lock: port1 mid-packet; port0 valid; select switched to 0.
//   -> all port1 beats emitted before any port0 beat; in_ready[0]=0 until port1 last accepted.
// - T5 backpressure: out_ready=0 for 4 cycles while out_valid=1.
//   -> out_data/out_last/out_port stable; in_ready all 0.
//   -> when out_ready returns to 1, the next beat is accepted in the same cycle.
// - T6 reset mid-packet: rst pulsed on the second of 4 beats from port3.
//   -> out_valid=0 next cycle; afterwards port0 is granted first in RR mode.

Source files
------------

// File: rtl/stream_mux_1ofn.sv
// N:1 registered stream mux with packet locking, fixed-select or round-robin arbitration.
// Latency: one cycle from input acceptance to out_*.
// Backpressure: in_ready is gated by a free or draining output register (!out_valid || out_ready).
module stream_mux_1ofn #(
    parameter  int NUM_PORTS_WIDTH = 2,
    parameter  int DATA_WIDTH      = 32,
    parameter  int RR_MODE         = 1,
    localparam int NUM_PORTS       = 2 ** NUM_PORTS_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS_WIDTH-1:0]      select,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    output logic [NUM_PORTS_WIDTH-1:0]      out_port
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                     state_q, state_d;
    logic [NUM_PORTS_WIDTH-1:0] grant_q, grant_d;
    logic [NUM_PORTS_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS_WIDTH-1:0] cand, idx, src;
    logic                       cand_vld;
    logic                       load_ok;
    logic                       xfer;
    logic [DATA_WIDTH-1:0]      port_data [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_split
        assign port_data[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign load_ok = !out_valid || out_ready;

    // Round-robin search starts one past the last granted port, wrapping naturally.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        idx      = '0;
        if (RR_MODE == 0) begin
            cand     = select;
            cand_vld = in_valid[select];
        end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                idx = rr_ptr_q + NUM_PORTS_WIDTH'(k);
                if (!cand_vld && in_valid[idx]) begin
                    cand     = idx;
                    cand_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        in_ready = '0;
        xfer     = 1'b0;
        src      = cand;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (cand_vld && load_ok) begin
                        in_ready[cand] = 1'b1;
                        xfer           = 1'b1;
                        rr_ptr_d       = cand;
                        if (!in_last[cand]) begin
                            state_d = LOCK;
                            grant_d = cand;
                        end
                    end
                end
                LOCK: begin
                    src = grant_q;
                    // A stalled owner keeps the lock; no other port may slip in.
                    in_ready[grant_q] = load_ok;
                    if (load_ok && in_valid[grant_q]) begin
                        xfer = 1'b1;
                        if (in_last[grant_q]) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= NUM_PORTS_WIDTH'(NUM_PORTS - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_port  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= port_data[src];
                out_last  <= in_last[src];
                out_port  <= src;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_1ofn.sv
// Bench for stream_mux_1ofn: one fixed-select and one round-robin instance share stimulus;
// accepted beats go into a scoreboard queue and are matched against the active instance's output.
module tb_stream_mux_1ofn;

    typedef struct {
        logic [1:0]  port;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic         clk;
    logic         rst;
    logic [1:0]   select;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_last;
    logic         out_ready;

    logic [3:0]   rdy0, rdy1;
    logic         ovld0, ovld1, olast0, olast1;
    logic [31:0]  odata0, odata1;
    logic [1:0]   oport0, oport1;

    logic         pv [4];
    logic [31:0]  pd [4];
    logic         pl [4];

    logic         act;
    logic [3:0]   mon_rdy;
    logic         mon_ovld, mon_olast;
    logic [31:0]  mon_odata;
    logic [1:0]   mon_oport;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic sb_en     = 1'b0;
    logic xfer_prev = 1'b0;
    logic t4_on     = 1'b0;
    logic p1_done   = 1'b0;
    beat_t sbq [$];
    int port_log [$];
    int cyc_log [$];

    stream_mux_1ofn #(.NUM_PORTS_WIDTH(2), .DATA_WIDTH(32), .RR_MODE(0)) dut_sel (
        .clk(clk), .rst(rst), .select(select), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .out_valid(ovld0), .out_ready(out_ready),
        .out_data(odata0), .out_last(olast0), .out_port(oport0));

    stream_mux_1ofn #(.NUM_PORTS_WIDTH(2), .DATA_WIDTH(32), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .select(select), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .out_valid(ovld1), .out_ready(out_ready),
        .out_data(odata1), .out_last(olast1), .out_port(oport1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        in_valid  = {pv[3], pv[2], pv[1], pv[0]};
        in_last   = {pl[3], pl[2], pl[1], pl[0]};
        in_data   = {pd[3], pd[2], pd[1], pd[0]};
        mon_rdy   = act ? rdy1   : rdy0;
        mon_ovld  = act ? ovld1  : ovld0;
        mon_olast = act ? olast1 : olast0;
        mon_odata = act ? odata1 : odata0;
        mon_oport = act ? oport1 : oport0;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output side of the scoreboard plus per-cycle handshake invariants.
    always @(negedge clk) begin
        beat_t e;
        if (sb_en) begin
            if (xfer_prev) chk_eq("latency_out_valid", 32'(mon_ovld), 32'd1);
            if (mon_ovld && out_ready) begin
                if (sbq.size() == 0) begin
                    chk_eq("sb_unexpected_out", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk_eq("out_port", 32'(mon_oport), 32'(e.port));
                    chk_eq("out_data", mon_odata, e.data);
                    chk_eq("out_last", 32'(mon_olast), 32'(e.last));
                    port_log.push_back(int'(mon_oport));
                    cyc_log.push_back(cyc);
                end
            end
            chk_eq("in_ready_onehot", 32'($countones(mon_rdy) > 1), 32'd0);
            if (t4_on && !p1_done) chk_eq("t4_lock_rdy0", 32'(mon_rdy[0]), 32'd0);
            xfer_prev = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && mon_rdy[i]) begin
                    sbq.push_back('{port: 2'(i), data: pd[i], last: pl[i]});
                    xfer_prev = 1'b1;
                    if (t4_on && i == 1 && pl[i]) p1_done = 1'b1;
                end
            end
        end
    end

    task automatic wait_accept(input int p);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (mon_rdy[p]) break;
            n++;
            if (n > 200) begin
                chk_eq("accept_timeout", 32'(mon_rdy[p]), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int p, input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            pv[p] = 1'b1;
            pd[p] = base + 32'(b);
            pl[p] = (b == n - 1);
            wait_accept(p);
        end
        pv[p] = 1'b0;
        pl[p] = 1'b0;
    endtask

    task automatic sb_clear();
        sbq.delete();
        port_log.delete();
        cyc_log.delete();
        xfer_prev = 1'b0;
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_clear();
        sb_en = 1'b1;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk_eq(tag, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] snap_data;
        logic        snap_last;
        logic [1:0]  snap_port;
        int          exp_t4 [6];

        rst = 1'b1; out_ready = 1'b1; select = 2'd0; act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b1; pd[i] = 32'hDEAD_0000 + 32'(i); pl[i] = 1'b0;
        end

        // T1: reset held with every port valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("t1_in_ready_sel", 32'(rdy0), 32'd0);
        chk_eq("t1_in_ready_rr", 32'(rdy1), 32'd0);
        chk_eq("t1_out_valid", 32'(ovld0), 32'd0);
        chk_eq("t1_out_data", odata0, 32'd0);
        chk_eq("t1_out_port", 32'(oport0), 32'd0);
        chk_eq("t1_out_last", 32'(olast1), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        rst = 1'b0;
        sb_clear();
        sb_en = 1'b1;

        // T2: fixed select, 3-beat packet from port 2
        select = 2'd2;
        send_pkt(2, 3, 32'hA0);
        drain("t2_drain");
        chk_eq("t2_beats", 32'(port_log.size()), 32'd3);

        // T4: port 1 locked mid-packet while select moves to 0 and port 0 becomes valid
        sb_clear();
        p1_done = 1'b0;
        t4_on   = 1'b1;
        select  = 2'd1;
        fork
            send_pkt(1, 4, 32'h100);
            begin
                repeat (2) @(posedge clk);
                #1;
                select = 2'd0;
                send_pkt(0, 2, 32'h200);
            end
        join
        drain("t4_drain");
        t4_on = 1'b0;
        exp_t4 = '{1, 1, 1, 1, 0, 0};
        chk_eq("t4_beats", 32'(port_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < port_log.size(); i++)
            chk_eq("t4_order", 32'(port_log[i]), 32'(exp_t4[i]));

        // T5: downstream stall for 4 cycles mid-packet
        sb_clear();
        select = 2'd0;
        fork
            send_pkt(0, 6, 32'h300);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk_eq("t5_out_valid", 32'(mon_ovld), 32'd1);
                snap_data = mon_odata; snap_last = mon_olast; snap_port = mon_oport;
                chk_eq("t5_rdy_stall", 32'(mon_rdy), 32'd0);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk_eq("t5_data_stable", mon_odata, snap_data);
                    chk_eq("t5_last_stable", 32'(mon_olast), 32'(snap_last));
                    chk_eq("t5_port_stable", 32'(mon_oport), 32'(snap_port));
                    chk_eq("t5_rdy_stall", 32'(mon_rdy), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                chk_eq("t5_resume_rdy", 32'(mon_rdy), 32'd1);
            end
        join
        drain("t5_drain");

        // T3: round robin, all ports streaming single-beat packets
        @(posedge clk);
        #1;
        act = 1'b1;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            fork
                automatic int q = p;
                begin
                    for (int k = 0; k < 3; k++) send_pkt(q, 1, 32'h400 + 32'(q * 16 + k));
                end
            join_none
        end
        wait fork;
        drain("t3_drain");
        chk_eq("t3_beats", 32'(port_log.size()), 32'd12);
        for (int i = 0; i < port_log.size(); i++) begin
            chk_eq("t3_rr_order", 32'(port_log[i]), 32'(i % 4));
            if (i > 0) chk_eq("t3_no_bubble", 32'(cyc_log[i]), 32'(cyc_log[i-1] + 1));
        end

        // T6: reset during the second beat of a 4-beat packet from port 3
        sb_en = 1'b0;
        pv[3] = 1'b1; pd[3] = 32'h600; pl[3] = 1'b0;
        @(negedge clk);
        chk_eq("t6_first_rdy", 32'(rdy1), 32'b1000);
        @(posedge clk);
        #1;
        pd[3] = 32'h601;
        rst = 1'b1;
        @(negedge clk);
        chk_eq("t6_rdy_in_rst", 32'(rdy1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pv[3] = 1'b0;
        @(negedge clk);
        chk_eq("t6_out_valid_dropped", 32'(ovld1), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b1; pd[i] = 32'h700 + 32'(i); pl[i] = 1'b1;
        end
        @(negedge clk);
        chk_eq("t6_port0_first", 32'(rdy1), 32'b0001);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        @(negedge clk);
        chk_eq("t6_out_port", 32'(oport1), 32'd0);
        chk_eq("t6_out_data", odata1, 32'h700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

endmodule
